// File: rtl/prio_irq_encoder.sv
// Priority interrupt encoder: sticky pending capture, masked grant selection
// (fixed-priority or round-robin) and a two-state present/acknowledge handshake.
module prio_irq_encoder #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3,
  parameter int unsigned RR   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic            ack,
  output logic            valid,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    pending
);

  // Catch bad parameterisations at elaboration time.
  if (IDXW != $clog2(N)) begin : g_bad_idxw
    $error("prio_irq_encoder: IDXW must equal $clog2(N)");
  end
  if (N < 2 || N > 64) begin : g_bad_n
    $error("prio_irq_encoder: N must be in 2..64");
  end

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    elig;
  logic [N-1:0]    clr;
  logic            accept;
  logic            sel_found;
  logic [IDXW-1:0] sel_idx;

  // Only an acknowledge of a presented grant counts; a stray ack is ignored.
  assign accept = ack && (state_q == StPresent);

  // Selection: scan from ptr (round-robin) or from 0 (fixed), wrapping mod N.
  always_comb begin
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    elig      = pending_q & mask;
    for (int k = 0; k < int'(N); k++) begin
      j = (RR != 0) ? int'(ptr_q) + k : k;
      if (j >= int'(N)) j = j - int'(N);
      if (!sel_found && elig[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(j);
      end
    end
  end

  // Next-state: pending capture (set wins over clear), FSM, index and pointer.
  always_comb begin
    clr       = accept ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
    pending_d = (pending_q & ~clr) | req;
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d = StPresent;
          idx_d   = sel_idx;
        end
      end
      StPresent: begin
        if (ack) begin
          state_d = StIdle;
          if (RR != 0) begin
            ptr_d = (int'(idx_q) == int'(N) - 1) ? '0 : idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign valid   = (state_q == StPresent);
  assign idx     = idx_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench: one fixed-priority and one round-robin instance, N=8.
module tb_prio_irq_encoder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ack_a, valid_a;
  logic [7:0] req_a, mask_a, pend_a;
  logic [2:0] idx_a;

  logic       rst_b, ack_b, valid_b;
  logic [7:0] req_b, mask_b, pend_b;
  logic [2:0] idx_b;

  int total = 0;
  int bad   = 0;

  prio_irq_encoder #(.N(8), .IDXW(3), .RR(0)) u_fix (
    .clk(clk), .rst(rst_a), .req(req_a), .mask(mask_a), .ack(ack_a),
    .valid(valid_a), .idx(idx_a), .pending(pend_a)
  );

  prio_irq_encoder #(.N(8), .IDXW(3), .RR(1)) u_rr (
    .clk(clk), .rst(rst_b), .req(req_b), .mask(mask_b), .ack(ack_b),
    .valid(valid_b), .idx(idx_b), .pending(pend_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int rr_exp[6] = '{0, 1, 7, 0, 1, 7};

  initial begin
    rst_a = 1'b1; req_a = 8'hFF; mask_a = 8'hFF; ack_a = 1'b1;
    rst_b = 1'b1; req_b = 8'hFF; mask_b = 8'hFF; ack_b = 1'b1;
    tick(); tick();
    chk("rst_pend", 32'(pend_a), 32'h00);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_idx", 32'(idx_a), 32'h0);
    rst_a = 1'b0; req_a = 8'h00; ack_a = 1'b0;
    rst_b = 1'b0; req_b = 8'h00; ack_b = 1'b0;
    tick();
    chk("rel_pend", 32'(pend_a), 32'h00);
    chk("rel_valid", 32'(valid_a), 32'h0);
    chk("rel_idx", 32'(idx_a), 32'h0);

    // Fixed priority.
    req_a = 8'b0010_1000;
    tick();
    chk("fx_pend28", 32'(pend_a), 32'h28);
    chk("fx_nolat", 32'(valid_a), 32'h0);
    req_a = 8'h00;
    tick();
    chk("fx_v3", 32'(valid_a), 32'h1);
    chk("fx_idx3", 32'(idx_a), 32'h3);
    ack_a = 1'b1;
    tick();
    chk("fx_bub1", 32'(valid_a), 32'h0);
    chk("fx_pend20", 32'(pend_a), 32'h20);
    ack_a = 1'b0;
    tick();
    chk("fx_v5", 32'(valid_a), 32'h1);
    chk("fx_idx5", 32'(idx_a), 32'h5);
    ack_a = 1'b1;
    tick();
    chk("fx_pend0", 32'(pend_a), 32'h00);
    ack_a = 1'b0;
    tick();
    chk("fx_empty", 32'(valid_a), 32'h0);

    // Masking and hold.
    mask_a = 8'hFD; req_a = 8'h02;
    tick();
    chk("mk_pend", 32'(pend_a), 32'h02);
    req_a = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mk_blocked", 32'(valid_a), 32'h0);
    end
    mask_a = 8'hFF;
    tick();
    chk("mk_v1", 32'(valid_a), 32'h1);
    chk("mk_idx1", 32'(idx_a), 32'h1);
    mask_a = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mk_hold_v", 32'(valid_a), 32'h1);
      chk("mk_hold_idx", 32'(idx_a), 32'h1);
    end
    ack_a = 1'b1;
    tick();
    chk("mk_ackv", 32'(valid_a), 32'h0);
    chk("mk_ackp", 32'(pend_a), 32'h00);
    ack_a = 1'b0; mask_a = 8'hFF;

    // Set wins over clear.
    req_a = 8'h10;
    tick();
    req_a = 8'h00;
    tick();
    chk("sw_v", 32'(valid_a), 32'h1);
    chk("sw_idx4", 32'(idx_a), 32'h4);
    ack_a = 1'b1; req_a = 8'h10;
    tick();
    chk("sw_bub", 32'(valid_a), 32'h0);
    chk("sw_pend", 32'(pend_a), 32'h10);
    ack_a = 1'b0; req_a = 8'h00;
    tick();
    chk("sw_v2", 32'(valid_a), 32'h1);
    chk("sw_idx4b", 32'(idx_a), 32'h4);
    ack_a = 1'b1;
    tick();
    chk("sw_clr", 32'(pend_a), 32'h00);
    ack_a = 1'b0;

    // Stray ack, then reset during PRESENT.
    ack_a = 1'b1;
    tick(); tick();
    chk("st_pend", 32'(pend_a), 32'h00);
    chk("st_valid", 32'(valid_a), 32'h0);
    ack_a = 1'b0; req_a = 8'hFF;
    tick();
    chk("mr_pend", 32'(pend_a), 32'hFF);
    req_a = 8'h00;
    tick();
    chk("mr_v", 32'(valid_a), 32'h1);
    chk("mr_idx0", 32'(idx_a), 32'h0);
    rst_a = 1'b1;
    tick();
    chk("mr_valid", 32'(valid_a), 32'h0);
    chk("mr_pend0", 32'(pend_a), 32'h00);
    rst_a = 1'b0;

    // Round-robin: stray ack must not move the pointer.
    mask_b = 8'h00; req_b = 8'h03;
    tick();
    chk("rs_pend", 32'(pend_b), 32'h03);
    req_b = 8'h00; ack_b = 1'b1;
    tick(); tick();
    chk("rs_pend2", 32'(pend_b), 32'h03);
    chk("rs_valid", 32'(valid_b), 32'h0);
    ack_b = 1'b0; mask_b = 8'hFF;
    tick();
    chk("rs_v", 32'(valid_b), 32'h1);
    chk("rs_idx0", 32'(idx_b), 32'h0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;

    // Round-robin grant sequence with constant requests.
    req_b = 8'b1000_0011;
    tick();
    chk("rr_pend", 32'(pend_b), 32'h83);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("rr_valid", 32'(valid_b), 32'h1);
      chk("rr_idx", 32'(idx_b), 32'(rr_exp[i]));
      ack_b = 1'b1;
      tick();
      chk("rr_bubble", 32'(valid_b), 32'h0);
      ack_b = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
